// File: rtl/popcount_neuron_seq.sv
// Ternary neuron sequencer: time-shares one combinational 16-bit popcount core
// over NWORDS words of pos/neg masked activations and thresholds the signed sum.
module popcount_neuron_seq #(
    parameter  int NWORDS = 4,
    localparam int SUM_W  = $clog2(32*NWORDS) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [16*NWORDS-1:0]       in_data,
    input  logic [16*NWORDS-1:0]       in_wpos,
    input  logic [16*NWORDS-1:0]       in_wneg,
    input  logic signed [SUM_W-1:0]    in_thr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [SUM_W-1:0]    out_sum,
    output logic                       out_fire,
    output logic                       busy,
    output logic [15:0]                pc_operand,
    input  logic [4:0]                 pc_count
);

    localparam int NPH = 2*NWORDS;
    localparam int PW  = (NPH > 1) ? $clog2(NPH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [16*NWORDS-1:0]    data;
        logic [16*NWORDS-1:0]    wpos;
        logic [16*NWORDS-1:0]    wneg;
        logic signed [SUM_W-1:0] thr;
    } job_t;

    state_t                  state;
    job_t                    job;
    logic signed [SUM_W-1:0] acc;
    logic [NPH-1:0]          pending;

    logic [NPH-1:0]          load;
    logic [NPH-1:0]          pend_next;
    logic [PW-1:0]           sel;
    logic [15:0]             operand;
    logic [SUM_W-1:0]        cnt_ext;
    logic signed [SUM_W-1:0] acc_next;
    int                      w;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Bit 2w is the pos phase of word w, bit 2w+1 the neg phase; empty masks never run.
    always_comb begin
        load = '0;
        for (int i = 0; i < NWORDS; i++) begin
            load[2*i]   = |in_wpos[16*i +: 16];
            load[2*i+1] = |in_wneg[16*i +: 16];
        end
    end

    always_comb begin
        sel = '0;
        for (int p = NPH-1; p >= 0; p--)
            if (pending[p]) sel = PW'(p);
        pend_next      = pending;
        pend_next[sel] = 1'b0;
        w       = int'(sel) >> 1;
        operand = job.data[16*w +: 16] &
                  (sel[0] ? job.wneg[16*w +: 16] : job.wpos[16*w +: 16]);
        cnt_ext  = {{(SUM_W-5){1'b0}}, pc_count};
        acc_next = sel[0] ? (acc - cnt_ext) : (acc + cnt_ext);
        pc_operand = (state == RUN) ? operand : 16'h0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            job       <= '0;
            acc       <= '0;
            pending   <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_fire  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    job     <= '{data: in_data, wpos: in_wpos, wneg: in_wneg, thr: in_thr};
                    acc     <= '0;
                    pending <= load;
                    if (load != '0) begin
                        state <= RUN;
                    end else begin
                        // Nothing to count: the sum is 0, so fire iff thr <= 0.
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_sum   <= '0;
                        out_fire  <= in_thr[SUM_W-1] || (in_thr == '0);
                    end
                end
                RUN: begin
                    acc     <= acc_next;
                    pending <= pend_next;
                    if (pend_next == '0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_sum   <= acc_next;
                        out_fire  <= (acc_next >= job.thr);
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_neuron_seq.sv
// Scoreboard bench for popcount_neuron_seq: a behavioural neuron model predicts
// sum, fire and latency per job; a negedge monitor checks the DUT's results.
module tb_popcount_neuron_seq;

    localparam int NWORDS = 4;
    localparam int SUM_W  = $clog2(32*NWORDS) + 1;
    localparam int DW     = 16*NWORDS;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [DW-1:0]           in_data, in_wpos, in_wneg;
    logic signed [SUM_W-1:0] in_thr;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [SUM_W-1:0] out_sum;
    logic                    out_fire;
    logic                    busy;
    logic [15:0]             pc_operand;
    logic [4:0]              pc_count;

    popcount_neuron_seq #(.NWORDS(NWORDS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_wpos(in_wpos), .in_wneg(in_wneg), .in_thr(in_thr),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_fire(out_fire), .busy(busy), .pc_operand(pc_operand), .pc_count(pc_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int mode  = 0;   // 0 exact core, 1 always 31, 2 exact but zero operand gives 2
    bit rdy_override = 1'b1;
    bit rdy_val      = 1'b1;

    typedef struct { int sum; bit fire; int lat; int acc_cyc; } exp_t;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] core(input logic [15:0] op, input int m);
        if (m == 1) return 5'd31;
        if (m == 2 && op == 16'h0) return 5'd2;
        return 5'($countones(op));
    endfunction

    always_comb pc_count = core(pc_operand, mode);

    function automatic void chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got timeout expected event", name);
    endfunction

    // Neuron as stated: sum over words of core(x&wpos) minus core(x&wneg), empty masks skipped.
    function automatic void model(input logic [DW-1:0] d, wp, wn, input int thr, m,
                                  output int sum, output bit fire, output int lat);
        sum = 0; lat = 0;
        for (int i = 0; i < NWORDS; i++) begin
            logic [15:0] x, p, n;
            x = d[16*i +: 16]; p = wp[16*i +: 16]; n = wn[16*i +: 16];
            if (p != 0) begin sum += int'(core(x & p, m)); lat++; end
            if (n != 0) begin sum -= int'(core(x & n, m)); lat++; end
        end
        fire = (sum >= thr);
    endfunction

    always @(posedge clk) begin
        #2;
        out_ready = rdy_override ? rdy_val : ($urandom_range(0, 2) != 0);
    end

    bit seen = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) seen = 1'b0;
        else if (out_valid) begin
            if (sb.size() == 0) fail_now("unexpected_out_valid");
            else begin
                if (!seen) begin
                    chk("latency", cyc - sb[0].acc_cyc, sb[0].lat);
                    seen = 1'b1;
                end
                if (out_ready) begin
                    chk("out_sum", int'(out_sum), sb[0].sum);
                    chk("out_fire", int'(out_fire), int'(sb[0].fire));
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [DW-1:0] d, wp, wn, input int thr, output int waits);
        exp_t e;
        in_data = d; in_wpos = wp; in_wneg = wn; in_thr = SUM_W'(thr); in_valid = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 300) begin
                fail_now("accept_timeout");
                break;
            end
        end
        model(d, wp, wn, thr, mode, e.sum, e.fire, e.lat);
        e.acc_cyc = cyc + 1;
        if (waits <= 300) sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 500) begin
            @(negedge clk); n++;
        end
        if (n >= 500) fail_now("drain_timeout");
        @(posedge clk); #1;
    endtask

    function automatic logic [DW-1:0] rnd_mask();
        logic [DW-1:0] m;
        for (int i = 0; i < NWORDS; i++) begin
            case ($urandom_range(0, 3))
                0:       m[16*i +: 16] = 16'h0000;
                1:       m[16*i +: 16] = 16'hFFFF;
                default: m[16*i +: 16] = 16'($urandom());
            endcase
        end
        return m;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wt, s1, l1;
        bit f1;
        logic [DW-1:0] ones, j1d, j1p, j1n;
        ones = '1;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_wpos = '0; in_wneg = '0; in_thr = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sum", int'(out_sum), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pc_operand", int'(pc_operand), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Abort a full job mid-RUN with reset.
        in_data = ones; in_wpos = ones; in_wneg = ones; in_thr = '0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("abort_busy", int'(busy), 1);
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_busy_low", int'(busy), 0);
        chk("abort_pc_operand", int'(pc_operand), 0);
        chk("abort_out_fire", int'(out_fire), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // All ones on the pos mask: four 0xFFFF operands, sum 64.
        mode = 0;
        send(ones, ones, '0, 64, wt);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("full_operand", int'(pc_operand), 16'hFFFF);
        end
        wait_idle();

        // No masks: immediate result, core never consulted.
        mode = 2;
        send(DW'($urandom()), '0, '0, 1, wt);
        @(negedge clk);
        chk("zero_operand", int'(pc_operand), 0);
        wait_idle();
        send(DW'($urandom()), '0, '0, 0, wt);
        wait_idle();

        // Word 0 only: second phase has a zero operand but a live mask.
        mode = 0;
        send(DW'(16'h00FF), DW'(16'h00FF), DW'(16'hFF00), 9, wt);
        @(negedge clk); chk("w0_op_pos", int'(pc_operand), 16'h00FF);
        @(negedge clk); chk("w0_op_neg", int'(pc_operand), 16'h0000);
        wait_idle();

        // Saturated core: extremes of the accumulator range.
        mode = 1;
        send(ones, ones, '0, 0, wt);
        wait_idle();
        send(ones, '0, ones, -124, wt);
        wait_idle();

        // Backpressure with a second job waiting on in_valid.
        mode = 0; rdy_val = 1'b0;
        j1d = DW'({$urandom(), $urandom()}); j1p = rnd_mask() | DW'(1); j1n = rnd_mask();
        model(j1d, j1p, j1n, 3, mode, s1, f1, l1);
        send(j1d, j1p, j1n, 3, wt);
        wt = 0;
        while (!out_valid && wt < 100) begin @(negedge clk); wt++; end
        if (wt >= 100) fail_now("bp_valid_timeout");
        in_data = ones; in_wpos = ones; in_wneg = '0; in_thr = '0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_sum", int'(out_sum), s1);
            chk("bp_fire", int'(out_fire), int'(f1));
            chk("bp_in_ready", int'(in_ready), 0);
        end
        @(posedge clk); #1;
        rdy_val = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        send(ones, ones, '0, 0, wt);
        chk("bp_accept_next", wt, 0);
        wait_idle();
        rdy_override = 1'b0;

        // Randomised jobs, back to back, core variant changed between groups.
        for (int g = 0; g < 3; g++) begin
            mode = g;
            for (int j = 0; j < 15; j++)
                send(DW'({$urandom(), $urandom()}), rnd_mask(), rnd_mask(),
                     int'($urandom_range(0, 160)) - 80, wt);
            wait_idle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/popcount_neuron_seq.md
# popcount_neuron_seq

Sequencer that time-shares one external 16-bit (exact or approximate) popcount core to evaluate a ternary neuron over an NWORDS×16-bit input vector. For each accepted job it computes sum = Σ popcount(x & w_pos) − Σ popcount(x & w_neg), one popcount per cycle, and compares the sum against a threshold. It sits between the sensor input buffer and the classifier output stage. The popcount core stays combinational outside this block, so any variant can be plugged in.

## Interface
- NWORDS, 4: number of 16-bit words per job, 1..16.
- SUM_W, $clog2(32*NWORDS)+1 (localparam): signed accumulator width; holds ±31·NWORDS, so overflow cannot occur.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  job offered.
- in_ready  out  1  block can accept a job.
- in_data  in  16*NWORDS  activations; word w = bits [16w+15:16w].
- in_wpos  in  16*NWORDS  +1 weight mask.
- in_wneg  in  16*NWORDS  −1 weight mask; bits set in both masks count both ways.
- in_thr  in  SUM_W  signed threshold.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed.
- out_sum  out  SUM_W  signed neuron sum.
- out_fire  out  1  out_sum >= in_thr (signed compare, threshold latched at accept).
- busy  out  1  state != IDLE.
- pc_operand  out  16  operand to the popcount core.
- pc_count  in  5  popcount core result, unsigned, 0..31.

## Operation
- Phases are numbered p = 2w+s, with s=0 (pos) and s=1 (neg). Phase operand = in_data word w & mask word w.
- At accept (in_valid && in_ready):
  - in_data, masks and in_thr are latched.
  - acc is cleared.
  - pending[2*NWORDS-1:0] is loaded with bit p = (mask word of p != 0).
- Zero-mask phases are skipped: they cost no cycle and add nothing. The core output for a zero operand is never used, because approximate cores may return nonzero for zero.
- FSM states:
  - IDLE: in_ready=1. On accept, go to RUN if pending != 0, else go to DONE with sum 0.
  - RUN: select the lowest set bit p of pending and drive pc_operand with that phase's operand. At the clock edge:
    - acc += zero-extended pc_count (pos phase) or acc -= pc_count (neg phase).
    - Clear bit p.
    - If it was the last pending bit, go to DONE and register out_sum = final acc and out_fire.
  - DONE: out_valid=1. out_sum and out_fire are held stable until out_valid && out_ready, then go to IDLE.
- in_ready is high only in IDLE. in_valid is ignored in every other state.
- pc_operand = 0 outside RUN.
- Reset (at any time, including mid-RUN or DONE):
  - State goes to IDLE and the job is discarded.
  - in_ready=1.
  - out_valid=0, out_sum=0, out_fire=0, busy=0, pc_operand=0.
  - acc, pending and all latches are cleared.

## Timing
- P = number of nonzero mask words (0..2·NWORDS).
- Accept at edge E0. out_valid rises at edge E0+P; for P=0 it is high in the cycle right after accept.
- pc_count is sampled in the same cycle pc_operand is driven. The core path is combinational, with no extra pipeline stage.
- Result stays in DONE for at least one cycle. Next accept is possible no earlier than the edge after the output handshake.
- Best-case throughput is one job per P+2 cycles.
- out_* are registered outputs; no combinational path from in_* to out_*.

## Test plan
- Reset: hold rst_n low mid-stream → all outputs 0 immediately and in_ready=1. Release, then run a job → correct result, no residue from the aborted job.
- NWORDS=4, exact core model. x=all ones, w_pos=all ones, w_neg=0, thr=64 → P=4. pc_operand=0xFFFF for 4 cycles, out_valid at E0+4, out_sum=64, out_fire=1.
- All masks zero, core model returns 2 for a zero operand → out_valid at E0, out_sum=0, pc_operand stays 0, out_fire = (0 >= thr); with thr=1, out_fire=0.
- Word0 only: x=0x00FF, w_pos=0x00FF, w_neg=0xFF00, thr=9 → P=2, operands 0x00FF then 0x0000. out_sum=8, out_fire=0.
- Core model always returns 31. w_pos all ones, w_neg=0, NWORDS=4 → out_sum=124, no wrap. Swap the masks → out_sum=−124.
- Backpressure: out_ready low for 5 cycles with in_valid held high → out_valid, out_sum and out_fire stable, in_ready=0. Raise out_ready → IDLE next cycle; the pending input is accepted on that edge.
